ps2_host_ctrl: RTL and testbench

Host-side PS/2 controller that owns the keyboard bus and sequences host-to-device command transfers (LED set 0xED, typematic 0xF3, reset 0xFF, …). It converts a command byte into the PS/2 request-to-send protocol on the open-drain clock/data lines, checks the device line-ack, then waits for the device response byte from the existing receive path. It also gates that receive path. It sits between the keyboard command source and the PS/2 pins, alongside the scan-code receiver.

---
 rtl/ps2_pkg.sv | 36 +++
 rtl/ps2_host_ctrl_if.sv | 29 ++
 rtl/ps2_line_sync.sv | 48 ++++
 rtl/ps2_host_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_ps2_host_ctrl.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 host-side controller.
//   state_t  - controller sequencing states
//   status_t - completion status codes reported with done
//   PS2_ACK / PS2_RESEND - device response bytes the controller acts on
//   odd_parity() - PS/2 frame parity for a data byte
package ps2_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SHIFT,
    S_LACK,
    S_RELEASE,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_NACK     = 2'd1,
    ST_TIMEOUT  = 2'd2,
    ST_BAD_RESP = 2'd3
  } status_t;

  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;

  localparam int TMR_W = 20;

  // PS/2 frames carry odd parity: the parity bit makes the total count of
  // ones across data+parity odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_ctrl_if.sv
// ps2_host_ctrl_if: command/result handshake between the keyboard command
// source (master) and the PS/2 host controller (slave).
//   cmd_valid/cmd_ready/cmd_byte - command offer, accepted when both high
//   busy      - controller is sequencing a transfer
//   done      - one-cycle completion pulse
//   status    - completion code, valid with done and held afterwards
//   resp_byte - last device response byte, held
interface ps2_host_ctrl_if;
  import ps2_pkg::*;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_byte;
  logic       busy;
  logic       done;
  status_t    status;
  logic [7:0] resp_byte;

  modport master (
    output cmd_valid, cmd_byte,
    input  cmd_ready, busy, done, status, resp_byte
  );

  modport slave (
    input  cmd_valid, cmd_byte,
    output cmd_ready, busy, done, status, resp_byte
  );

endinterface

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: brings the asynchronous PS/2 clock and data pins into the
// clk domain and flags falling edges of the PS/2 clock.
//   clk, rst  - system clock, synchronous active-high reset
//   ps2_clk   - raw PS/2 clock pin level
//   ps2_dat   - raw PS/2 data pin level
//   clk_sync  - synchronized clock level
//   dat_sync  - synchronized data level
//   clk_fall  - one-cycle pulse, synchronized clock went high->low
// A pin falling edge shows up on clk_fall two cycles later, so a consumer
// registering a response sees it on the third cycle.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic clk_sync,
  output logic dat_sync,
  output logic clk_fall
);

  logic clk_meta;
  logic dat_meta;
  logic clk_prev;

  // Reset to the idle bus level (both lines high) so leaving reset never
  // produces a spurious falling edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always written with non-blocking assignments
    // so every register samples pre-edge values regardless of statement order.
    if (rst) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      clk_prev <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      clk_meta <= ps2_clk;
      clk_sync <= clk_meta;
      clk_prev <= clk_sync;
      dat_meta <= ps2_dat;
      dat_sync <= dat_meta;
    end
  end

  // Both operands are registers, so the pulse is glitch-free.
  assign clk_fall = clk_prev & ~clk_sync;

endmodule

// File: rtl/ps2_host_ctrl.sv
// ps2_host_ctrl: host-to-device PS/2 command sequencer.
//   clk, rst               - system clock, synchronous active-high reset
//   PS2_KBCLK, PS2_KBDAT   - raw PS/2 pin levels (asynchronous)
//   ps2_clk_oe, ps2_dat_oe - 1 pulls the open-drain clock/data line low
//   cmd                    - command/result handshake (slave side)
//   rx_valid, rx_byte      - bytes from the existing scan-code receiver
//   rx_en                  - receiver enable, low while the host owns the bus
// Flow: inhibit the clock, request-to-send, shift 8 data bits + parity +
// stop on device clock falling edges, check the line-ack, then wait for the
// device response (ACK / RESEND with bounded retries).
module ps2_host_ctrl
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC  = 5000,
  parameter int START_TO_CYC = 750000,
  parameter int BIT_TO_CYC   = 100000,
  parameter int RESP_TO_CYC  = 1000000,
  parameter int MAX_RETRY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PS2_KBCLK,
  input  logic                  PS2_KBDAT,
  output logic                  ps2_clk_oe,
  output logic                  ps2_dat_oe,
  ps2_host_ctrl_if.slave        cmd,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  output logic                  rx_en
);

  localparam logic [TMR_W-1:0] INH_LIM   = TMR_W'(INHIBIT_CYC);
  localparam logic [TMR_W-1:0] START_LIM = TMR_W'(START_TO_CYC);
  localparam logic [TMR_W-1:0] BIT_LIM   = TMR_W'(BIT_TO_CYC);
  localparam logic [TMR_W-1:0] RESP_LIM  = TMR_W'(RESP_TO_CYC);
  localparam logic [3:0]       RETRY_LIM = 4'(MAX_RETRY);

  logic clk_sync;
  logic dat_sync;
  logic clk_fall;

  ps2_line_sync u_line_sync (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (PS2_KBCLK),
    .ps2_dat  (PS2_KBDAT),
    .clk_sync (clk_sync),
    .dat_sync (dat_sync),
    .clk_fall (clk_fall)
  );

  state_t           state;
  logic [7:0]       tx_byte;
  logic             tx_par;
  logic [3:0]       edge_cnt;   // device falling edges seen so far
  logic [3:0]       retry_cnt;
  logic [TMR_W-1:0] tmr;        // cycles in the current wait, current cycle included
  logic [TMR_W-1:0] tmr_inc;
  logic [3:0]       edge_num;

  logic             term;
  status_t          term_st;

  assign tmr_inc  = (&tmr) ? tmr : tmr + TMR_W'(1);
  assign edge_num = edge_cnt + 4'd1;

  assign cmd.cmd_ready = (state == S_IDLE);
  assign cmd.busy      = (state != S_IDLE);

  // Terminal conditions are decided here once, so every exit path applies
  // the same cleanup in the sequential block.
  always_comb begin
    // NOTE: every combinational output gets a default first; without it a
    // path that skips the assignment would infer a latch.
    term    = 1'b0;
    term_st = ST_OK;
    case (state)
      S_SHIFT: begin
        if (!clk_fall && tmr >= ((edge_cnt == 4'd0) ? START_LIM : BIT_LIM)) begin
          term    = 1'b1;
          term_st = ST_TIMEOUT;
        end
      end
      S_LACK: begin
        if (clk_fall) begin
          if (dat_sync) begin
            term    = 1'b1;
            term_st = ST_NACK;
          end
        end else if (tmr >= BIT_LIM) begin
          term    = 1'b1;
          term_st = ST_TIMEOUT;
        end
      end
      S_RELEASE: begin
        if (!(clk_sync && dat_sync) && tmr >= BIT_LIM) begin
          term    = 1'b1;
          term_st = ST_TIMEOUT;
        end
      end
      S_RESP: begin
        if (rx_valid) begin
          if (rx_byte == PS2_ACK) begin
            term    = 1'b1;
            term_st = ST_OK;
          end else if (!(rx_byte == PS2_RESEND && retry_cnt < RETRY_LIM)) begin
            term    = 1'b1;
            term_st = ST_BAD_RESP;
          end
        end else if (tmr >= RESP_LIM) begin
          term    = 1'b1;
          term_st = ST_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      ps2_clk_oe    <= 1'b0;
      ps2_dat_oe    <= 1'b0;
      rx_en         <= 1'b1;
      cmd.done      <= 1'b0;
      cmd.status    <= ST_OK;
      cmd.resp_byte <= 8'h00;
      tx_byte       <= 8'h00;
      tx_par        <= 1'b0;
      edge_cnt      <= 4'd0;
      retry_cnt     <= 4'd0;
      tmr           <= '0;
    end else begin
      cmd.done <= 1'b0;

      // Any byte arriving while waiting for the response is recorded,
      // including RESEND bytes that trigger a retry.
      if (state == S_RESP && rx_valid) cmd.resp_byte <= rx_byte;

      if (term) begin
        state      <= S_IDLE;
        cmd.done   <= 1'b1;
        cmd.status <= term_st;
        ps2_clk_oe <= 1'b0;
        ps2_dat_oe <= 1'b0;
        rx_en      <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (cmd.cmd_valid) begin
              tx_byte    <= cmd.cmd_byte;
              tx_par     <= odd_parity(cmd.cmd_byte);
              retry_cnt  <= 4'd0;
              state      <= S_INHIBIT;
              ps2_clk_oe <= 1'b1;
              ps2_dat_oe <= 1'b0;
              rx_en      <= 1'b0;
              tmr        <= TMR_W'(1);
            end
          end

          // Clock held low; the start bit (data low) goes out in the last
          // inhibit cycle so it is settled before the clock is released.
          S_INHIBIT: begin
            tmr <= tmr_inc;
            if (tmr == INH_LIM - TMR_W'(1)) ps2_dat_oe <= 1'b1;
            if (tmr == INH_LIM)             state      <= S_RTS;
          end

          S_RTS: begin
            ps2_clk_oe <= 1'b0;
            edge_cnt   <= 4'd0;
            tmr        <= TMR_W'(1);
            state      <= S_SHIFT;
          end

          // Edges 1-8 present data LSB first, 9 parity, 10 releases data
          // for the stop bit; the line is pulled low to send a 0.
          S_SHIFT: begin
            if (clk_fall) begin
              tmr      <= TMR_W'(1);
              edge_cnt <= edge_num;
              if (edge_num <= 4'd8) begin
                ps2_dat_oe <= ~tx_byte[edge_cnt[2:0]];
              end else if (edge_num == 4'd9) begin
                ps2_dat_oe <= ~tx_par;
              end else begin
                ps2_dat_oe <= 1'b0;
                state      <= S_LACK;
              end
            end else begin
              tmr <= tmr_inc;
            end
          end

          // Edge 11: device holds data low to acknowledge the frame.
          S_LACK: begin
            if (clk_fall) begin
              tmr   <= TMR_W'(1);
              state <= S_RELEASE;
            end else begin
              tmr <= tmr_inc;
            end
          end

          S_RELEASE: begin
            if (clk_sync && dat_sync) begin
              rx_en <= 1'b1;
              tmr   <= TMR_W'(1);
              state <= S_RESP;
            end else begin
              tmr <= tmr_inc;
            end
          end

          // Only a RESEND with retries left reaches here without terminating.
          S_RESP: begin
            if (rx_valid) begin
              retry_cnt  <= retry_cnt + 4'd1;
              state      <= S_INHIBIT;
              ps2_clk_oe <= 1'b1;
              ps2_dat_oe <= 1'b0;
              rx_en      <= 1'b0;
              tmr        <= TMR_W'(1);
            end else begin
              tmr <= tmr_inc;
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// tb_ps2_host_ctrl: directed bench for ps2_host_ctrl with an open-drain bus
// and a behavioural keyboard that clocks frames, line-acks and answers.
module tb_ps2_host_ctrl;

  localparam int INH   = 8;
  localparam int STO   = 200;
  localparam int BTO   = 100;
  localparam int RTO   = 300;
  localparam int HALF  = 20;   // device clock half period, in clk cycles

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk_oe, ps2_dat_oe, rx_en;
  logic rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic dev_clk = 1'b0;   // 1 = device pulls clock low
  logic dev_dat = 1'b0;   // 1 = device pulls data low
  wire  line_clk = ~(ps2_clk_oe | dev_clk);
  wire  line_dat = ~(ps2_dat_oe | dev_dat);

  ps2_host_ctrl_if bus();

  ps2_host_ctrl #(
    .INHIBIT_CYC (INH),
    .START_TO_CYC(STO),
    .BIT_TO_CYC  (BTO),
    .RESP_TO_CYC (RTO),
    .MAX_RETRY   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .PS2_KBCLK (line_clk),
    .PS2_KBDAT (line_dat),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .cmd       (bus.slave),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .rx_en     (rx_en)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int inh_cnt  = 0;
  logic clk_oe_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt++;
    if (ps2_clk_oe === 1'b1 && clk_oe_prev !== 1'b1) inh_cnt++;
    clk_oe_prev = ps2_clk_oe;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic [7:0] b);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_byte  = b;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // Keyboard side of a host-to-device frame. Samples each bit on the rising
  // clock edge, pulls data low between edges 10 and 11 when ack is set.
  task automatic dev_xfer(input bit ack, input int n_edges, input bit inject,
                          output logic [7:0] data, output logic par, output logic stop);
    int t;
    data = 8'h00; par = 1'b0; stop = 1'b0;
    t = 0;
    while (!(ps2_dat_oe === 1'b1 && ps2_clk_oe === 1'b0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("dev_rts_seen", 32'(t < 3000), 32'd1);
    if (t >= 3000) return;
    repeat (10) @(negedge clk);
    for (int e = 1; e <= n_edges; e++) begin
      dev_clk = 1'b1;
      if (inject && e == 3) begin
        rx_valid = 1'b1;
        rx_byte  = 8'h55;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (HALF - 1) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      dev_clk = 1'b0;
      if (e <= 8)       data[e-1] = line_dat;
      else if (e == 9)  par = line_dat;
      else if (e == 10) begin
        stop = line_dat;
        if (ack) dev_dat = 1'b1;
      end else          dev_dat = 1'b0;
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic respond(input logic [7:0] b);
    int t;
    t = 0;
    while (!(rx_en === 1'b1 && bus.busy === 1'b1) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("resp_window", 32'(t < 2000), 32'd1);
    repeat (5) @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int base);
    int t;
    t = 0;
    while (done_cnt <= base && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(done_cnt - base), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic p, s;
    int base, ibase, cnt;

    bus.cmd_valid = 1'b0;
    bus.cmd_byte  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_rx_en", 32'(rx_en), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_status", 32'(bus.status), 32'd0);
    check("rst_resp", 32'(bus.resp_byte), 32'h00);

    // 0xED with inhibit/RTS timing, full frame, ACK
    base = done_cnt;
    send_cmd(8'hED);                       // now in cycle N+1
    check("inh_clk_oe", 32'(ps2_clk_oe), 32'd1);
    check("inh_dat_oe", 32'(ps2_dat_oe), 32'd0);
    check("inh_rx_en", 32'(rx_en), 32'd0);
    check("inh_busy_ready", 32'({bus.busy, bus.cmd_ready}), 32'b10);
    repeat (INH - 2) @(negedge clk);       // N+INH-1
    check("inh_last_minus1_dat", 32'(ps2_dat_oe), 32'd0);
    @(negedge clk);                        // N+INH
    check("inh_last_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'b11);
    @(negedge clk);                        // N+INH+1 (RTS)
    check("rts_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'b11);
    @(negedge clk);                        // N+INH+2
    check("release_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'b01);
    dev_xfer(1'b1, 11, 1'b0, d, p, s);
    check("ed_data", 32'(d), 32'hED);
    check("ed_parity", 32'(p), 32'd1);
    check("ed_stop", 32'(s), 32'd1);
    respond(8'hFA);
    wait_done("ed_done", base);
    check("ed_status", 32'(bus.status), 32'd0);
    check("ed_resp", 32'(bus.resp_byte), 32'hFA);
    repeat (3) @(negedge clk);
    check("ed_single_done", 32'(done_cnt - base), 32'd1);

    // Device never clocks: timeout exactly STO cycles after release
    send_cmd(8'hFF);
    cnt = 0;
    while (ps2_clk_oe === 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    cnt = 0;
    while (bus.done !== 1'b1 && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    check("start_to_cycles", 32'(cnt), 32'(STO));
    check("start_to_status", 32'(bus.status), 32'd2);
    check("start_to_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'b00);

    // No line-ack: NACK without waiting for a response
    repeat (5) @(negedge clk);
    base = done_cnt;
    send_cmd(8'hF3);
    dev_xfer(1'b0, 11, 1'b0, d, p, s);
    wait_done("nack_done", base);
    check("nack_status", 32'(bus.status), 32'd1);
    check("nack_idle", 32'({bus.busy, rx_en}), 32'b01);

    // RESEND, RESEND, ACK: three transmissions, OK
    repeat (5) @(negedge clk);
    base  = done_cnt;
    ibase = inh_cnt;
    send_cmd(8'h12);
    for (int k = 0; k < 3; k++) begin
      dev_xfer(1'b1, 11, 1'b0, d, p, s);
      check("retry_data", 32'(d), 32'h12);
      respond((k == 2) ? 8'hFA : 8'hFE);
    end
    wait_done("retry_done", base);
    check("retry_inhibits", 32'(inh_cnt - ibase), 32'd3);
    check("retry_status", 32'(bus.status), 32'd0);

    // RESEND on every transmission: retries exhausted, BAD_RESP
    repeat (5) @(negedge clk);
    base  = done_cnt;
    ibase = inh_cnt;
    send_cmd(8'h34);
    for (int k = 0; k < 3; k++) begin
      dev_xfer(1'b1, 11, 1'b0, d, p, s);
      respond(8'hFE);
    end
    wait_done("bad_done", base);
    check("bad_inhibits", 32'(inh_cnt - ibase), 32'd3);
    check("bad_status", 32'(bus.status), 32'd3);
    check("bad_resp", 32'(bus.resp_byte), 32'hFE);

    // Reset after edge 5: immediate return to idle, no done pulse
    repeat (5) @(negedge clk);
    base = done_cnt;
    send_cmd(8'hED);
    dev_xfer(1'b1, 5, 1'b0, d, p, s);
    check("rst_mid_busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'b00);
    check("rst_mid_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_mid_status", 32'(bus.status), 32'd0);
    rst = 1'b0;
    repeat (400) @(negedge clk);
    check("rst_mid_no_done", 32'(done_cnt - base), 32'd0);

    // cmd_valid held with a new byte during a transfer; rx during SHIFT
    base  = done_cnt;
    ibase = inh_cnt;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_byte  = 8'hED;
    @(negedge clk);
    bus.cmd_byte  = 8'hF3;
    dev_xfer(1'b1, 11, 1'b1, d, p, s);
    check("hold_first_data", 32'(d), 32'hED);
    check("shift_rx_ignored", 32'(bus.resp_byte), 32'h00);
    respond(8'hFA);
    cnt = 0;
    while (bus.done !== 1'b1 && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    check("hold_done_seen", 32'(cnt < 1000), 32'd1);
    check("hold_single_inhibit", 32'(inh_cnt - ibase), 32'd1);
    check("hold_ready_at_done", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    check("hold_accepted_after", 32'({bus.busy, ps2_clk_oe}), 32'b11);
    bus.cmd_valid = 1'b0;
    dev_xfer(1'b1, 11, 1'b0, d, p, s);
    check("hold_second_data", 32'(d), 32'hF3);
    check("hold_second_parity", 32'(p), 32'd1);
    respond(8'hFA);
    wait_done("hold_second_done", base + 1);
    check("hold_second_status", 32'(bus.status), 32'd0);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
